// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - per-channel synchronizer with stability filter, edge pulses and sticky glitch flags
//
// Purpose:
//   Brings WIDTH asynchronous level inputs into the sys_clk domain through a
//   STAGES-deep flop chain, then only lets a channel's output follow the
//   synchronized level once it has disagreed with the output for FILTER_LEN
//   consecutive edges. Each accepted change produces a one-cycle rise_o or
//   fall_o pulse; each rejected transient sets a sticky glitch_o bit.
//
// Ports:
//   sys_clk       in   1      rising-edge clock for every flop
//   rstn_i        in   1      asynchronous active-low reset (release expected
//                             to be already synchronous to sys_clk)
//   data_in       in   WIDTH  asynchronous level inputs
//   glitch_clr_i  in   WIDTH  synchronous per-channel clear of glitch_o
//   sync_out      out  WIDTH  synchronized, filtered levels
//   rise_o        out  WIDTH  one-cycle pulse on each accepted 0->1 change
//   fall_o        out  WIDTH  one-cycle pulse on each accepted 1->0 change
//   glitch_o      out  WIDTH  sticky flag per rejected transient
module sync_edge_filter #(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      STAGES     = 2,
  parameter int unsigned      FILTER_LEN = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             sys_clk,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] glitch_clr_i,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] glitch_o
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // Synchronizer chain: stage 0 samples data_in directly, no logic in between.
  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge sys_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= RESET_VAL;
    end else begin
      chain[0] <= data_in;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic             s;
    logic             differ;
    logic             at_last;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             glitch_q;

    assign s       = chain[STAGES-1][g];
    assign differ  = s ^ level_q;
    // With FILTER_LEN=1 CNT_LAST is 0, so the first disagreement is accepted
    // and cnt never leaves zero, which also keeps glitch detection silent.
    assign at_last = (cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt      <= '0;
        level_q  <= RESET_VAL[g];
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        rise_q   <= differ & at_last & s;
        fall_q   <= differ & at_last & ~s;
        // A disagreement run that ends before acceptance is a glitch; the set
        // term wins over a simultaneous clear.
        glitch_q <= (~differ & (cnt != '0)) | (glitch_q & ~glitch_clr_i[g]);
        if (!differ) begin
          cnt <= '0;
        end else if (at_last) begin
          level_q <= s;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign sync_out[g] = level_q;
    assign rise_o[g]   = rise_q;
    assign fall_o[g]   = fall_q;
    assign glitch_o[g] = glitch_q;
  end

endmodule

// File: doc/sync_edge_filter.md
SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

Interface
REQ-001 SHALL provide parameter WIDTH, default 1, giving the number of independent single-bit channels (1..32).
REQ-002 SHALL provide parameter STAGES, default 2, giving the synchronizer flop depth per channel (2..4).
REQ-003 SHALL provide parameter FILTER_LEN, default 1, giving the consecutive stable cycles required before an output changes (1..255); the value 1 disables filtering.
REQ-004 SHALL provide parameter RESET_VAL, default {WIDTH{1'b0}}, giving the per-channel reset level for all storage.
REQ-005 SHALL provide port sys_clk, input, 1, the single clock; all flops are rising-edge triggered.
REQ-006 SHALL provide port rstn_i, input, 1, the asynchronous active-low reset; assertion is immediate and removal is synchronous to sys_clk.
REQ-007 SHALL provide port data_in, input, WIDTH, the asynchronous level inputs, one per channel.
REQ-008 SHALL provide port glitch_clr_i, input, WIDTH, a synchronous per-channel clear of the glitch_o bits.
REQ-009 SHALL provide port sync_out, output reg, WIDTH, the synchronized and filtered levels.
REQ-010 SHALL provide port rise_o, output reg, WIDTH, a one-cycle pulse on each filtered 0->1 change.
REQ-011 SHALL provide port fall_o, output reg, WIDTH, a one-cycle pulse on each filtered 1->0 change.
REQ-012 SHALL provide port glitch_o, output reg, WIDTH, a sticky flag per channel for each rejected input transient.

Function
REQ-013 SHALL clock each data_in bit through a chain of STAGES flops; no combinational logic sits between data_in and the first flop, or between chain flops.
REQ-014 SHALL define s[i] as the last chain flop of channel i, which reflects data_in[i] STAGES edges after data_in[i] is sampled.
REQ-015 SHALL keep one counter per channel, ceil(log2(FILTER_LEN+1)) bits wide, which clears whenever s[i]==sync_out[i].
REQ-016 SHALL increment the counter on each edge where s[i]!=sync_out[i] and the count is below FILTER_LEN-1.
REQ-017 SHALL, on an edge where s[i]!=sync_out[i] and the count equals FILTER_LEN-1, load sync_out[i]<=s[i] and clear the counter.
REQ-018 SHALL, with FILTER_LEN=1, update sync_out[i] on the first edge that s[i] disagrees; total latency from data_in sampling to sync_out is then STAGES+1 edges.
REQ-019 SHALL have a general total latency of STAGES+FILTER_LEN edges for a step input held stable.
REQ-020 SHALL assert rise_o[i] for exactly one cycle, registered on the same edge that sync_out[i] goes 0->1; fall_o[i] behaves likewise for 1->0.
REQ-021 SHALL never assert rise_o[i] and fall_o[i] in the same cycle.
REQ-022 SHALL set glitch_o[i] when s[i] returns to equal sync_out[i] while the counter is non-zero (transient shorter than FILTER_LEN cycles).
REQ-023 SHALL never set glitch_o when FILTER_LEN=1.
REQ-024 SHALL give glitch set priority over glitch_clr_i[i] on the same edge; the flag remains 1.
REQ-025 SHALL keep glitch_o[i] at 1 until cleared by glitch_clr_i[i] or by reset.
REQ-026 SHALL keep channels fully independent; simultaneous events on several channels are each handled as if alone.
REQ-027 SHALL never wrap the counter; the maximum value is FILTER_LEN-1.

Reset
REQ-028 SHALL, while rstn_i=0, force chain flops and sync_out to RESET_VAL, and counters, rise_o, fall_o and glitch_o to 0.
REQ-029 SHALL abandon any count in progress when reset asserts mid-filter; no pulse or glitch is produced for that count after release.
REQ-030 SHALL produce no rise_o or fall_o pulse on the first edge after reset release, even when data_in differs from RESET_VAL; the change propagates with normal latency and then pulses once.

Verification
REQ-031 SHALL cover: WIDTH=1, STAGES=2, FILTER_LEN=1, data_in 0->1 -> sync_out=1 and rise_o pulse one cycle on the 3rd edge after sampling.
REQ-032 SHALL cover: STAGES=3, FILTER_LEN=4, data_in high for 3 cycles then low -> sync_out stays 0, no rise_o, glitch_o=1.
REQ-033 SHALL cover: FILTER_LEN=4, data_in high held -> sync_out rises on edge 3+4=7, a single rise_o; a later 1->0 gives a single fall_o.
REQ-034 SHALL cover: WIDTH=4, channels 0 and 2 toggled on the same edge -> independent, identically timed pulses, with channels 1 and 3 quiet.
REQ-035 SHALL cover: rstn_i asserted at count 2 of 4 -> all outputs reset immediately; after release with data_in=1, rise_o fires only after the full STAGES+FILTER_LEN latency.
REQ-036 SHALL cover: glitch_clr_i and a glitch on the same edge -> glitch_o remains 1; glitch_clr_i alone -> glitch_o=0 on the next edge.
